// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the unified port: the arbiter is master, the memory is slave.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken over a waiting fetch.
// rst is asynchronous and active-low.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    if_req,
  input  logic [AW-1:0]           if_addr,
  output logic [DW-1:0]           if_rdata,
  output logic                    if_done,

  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [AW-1:0]           dm_addr,
  input  logic [DW-1:0]           dm_wdata,
  output logic [DW-1:0]           dm_rdata,
  output logic                    dm_done,

  mem_port_arbiter_if.master      mem,

  output logic                    stall_if,
  output logic                    stall_mem,
  output logic                    busy,
  output logic                    owner
);

  localparam int unsigned CW         = 4;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   starve_q,    starve_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
  logic            if_done_q,   if_done_d;
  logic            dm_done_q,   dm_done_d;
  logic            owner_q,     owner_d;

  // A request seen in its own done cycle is the one just served, so it is masked.
  logic if_elig;
  logic dm_elig;
  logic grant_fetch;
  logic grant_data;

  // Arbitration decision, only acted on in IDLE.
  always_comb begin
    if_elig     = if_req & ~if_done_q;
    dm_elig     = dm_req & ~dm_done_q;
    grant_fetch = if_elig & (~dm_elig | (starve_q == STARVE_MAX));
    grant_data  = dm_elig & ~grant_fetch;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    owner_d     = owner_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_fetch) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          owner_d    = 1'b0;
          starve_d   = '0;
        end else if (grant_data) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          owner_d     = 1'b1;
          if (if_elig && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end

      ST_FETCH: begin
        if (mem.mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_rdata_d = mem.mem_rdata;
          if_done_d  = 1'b1;
        end
      end

      ST_DATA: begin
        if (mem.mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          dm_done_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem.mem_rdata;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      owner_q     <= owner_d;
    end
  end

  // Output drive; stalls hold a stage until its done pulse.
  always_comb begin
    mem.mem_req   = mem_req_q;
    mem.mem_we    = mem_we_q;
    mem.mem_addr  = mem_addr_q;
    mem.mem_wdata = mem_wdata_q;
    if_rdata      = if_rdata_q;
    if_done       = if_done_q;
    dm_rdata      = dm_rdata_q;
    dm_done       = dm_done_q;
    busy          = mem_req_q;
    owner         = owner_q;
    stall_if      = if_req & ~if_done_q;
    stall_mem     = dm_req & ~dm_done_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled at negedge.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          stall_if;
  logic          stall_mem;
  logic          busy;
  logic          owner;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem       (mem_if.master),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;

    // Reset values
    tick(); tick();
    chk("rst_mem_req",   32'(mem_if.mem_req), 0);
    chk("rst_mem_we",    32'(mem_if.mem_we),  0);
    chk("rst_mem_addr",  mem_if.mem_addr,     0);
    chk("rst_mem_wdata", mem_if.mem_wdata,    0);
    chk("rst_if_done",   32'(if_done),        0);
    chk("rst_dm_done",   32'(dm_done),        0);
    chk("rst_busy",      32'(busy),           0);
    chk("rst_owner",     32'(owner),          0);
    chk("rst_if_rdata",  if_rdata,            0);
    chk("rst_dm_rdata",  dm_rdata,            0);
    chk("rst_starve",    32'(dut.starve_q),   0);
    rst = 1'b1;
    tick();

    // Lone fetch, zero wait
    if_req = 1'b1; if_addr = 32'h40;
    #1 chk("f_stall_c0", 32'(stall_if), 1);
    chk("f_req_c0", 32'(mem_if.mem_req), 0);
    tick();
    chk("f_req_c1",   32'(mem_if.mem_req), 1);
    chk("f_addr_c1",  mem_if.mem_addr,     32'h40);
    chk("f_we_c1",    32'(mem_if.mem_we),  0);
    chk("f_busy_c1",  32'(busy),           1);
    chk("f_owner_c1", 32'(owner),          0);
    chk("f_stall_c1", 32'(stall_if),       1);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h8C220004;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("f_done_c2",  32'(if_done),        1);
    chk("f_rdata_c2", if_rdata,            32'h8C220004);
    chk("f_req_c2",   32'(mem_if.mem_req), 0);
    chk("f_stall_c2", 32'(stall_if),       0);
    if_req = 1'b0;
    tick();
    chk("f_done_c3",  32'(if_done), 0);
    chk("f_rdata_c3", if_rdata,     32'h8C220004);

    // Simultaneous fetch and load: data first, bubble, then fetch
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    tick();
    chk("s_owner_c1", 32'(owner),          1);
    chk("s_addr_c1",  mem_if.mem_addr,     32'h200);
    chk("s_we_c1",    32'(mem_if.mem_we),  0);
    chk("s_stif_c1",  32'(stall_if),       1);
    chk("s_starve_c1", 32'(dut.starve_q),  1);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE0001;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("s_dmdone_c2", 32'(dm_done),        1);
    chk("s_dmrd_c2",   dm_rdata,            32'hCAFE0001);
    chk("s_bubble_c2", 32'(mem_if.mem_req), 0);
    chk("s_stmem_c2",  32'(stall_mem),      0);
    chk("s_stif_c2",   32'(stall_if),       1);
    dm_req = 1'b0;
    tick();
    chk("s_req_c3",    32'(mem_if.mem_req), 1);
    chk("s_owner_c3",  32'(owner),          0);
    chk("s_addr_c3",   mem_if.mem_addr,     32'h80);
    chk("s_starve_c3", 32'(dut.starve_q),   0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h11110000;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("s_ifdone_c4", 32'(if_done), 1);
    chk("s_ifrd_c4",   if_rdata,     32'h11110000);
    if_req = 1'b0;
    tick();

    // Store with three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("st_req",   32'(mem_if.mem_req), 1);
      chk("st_we",    32'(mem_if.mem_we),  1);
      chk("st_addr",  mem_if.mem_addr,     32'h100);
      chk("st_wdata", mem_if.mem_wdata,    32'hDEADBEEF);
      chk("st_done",  32'(dm_done),        0);
      chk("st_stall", 32'(stall_mem),      1);
      if (c == 2) begin
        dm_addr = 32'h999; dm_wdata = 32'h0BADF00D;
      end
      if (c == 4) begin
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h12345678;
      end
    end
    tick();
    mem_if.mem_ack = 1'b0;
    chk("st_done_c5",  32'(dm_done),        1);
    chk("st_rdata_c5", dm_rdata,            32'hCAFE0001);
    chk("st_we_c5",    32'(mem_if.mem_we),  0);
    chk("st_req_c5",   32'(mem_if.mem_req), 0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("st_done_c6", 32'(dm_done), 0);

    // Done-cycle masking: dm_req held through dm_done
    dm_req = 1'b1; dm_addr = 32'h300;
    tick();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("m_done_c2", 32'(dm_done), 1);
    chk("m_rd_c2",   dm_rdata,     32'hA5A5A5A5);
    dm_addr = 32'h304;
    tick();
    chk("m_nogrant_c3", 32'(mem_if.mem_req), 0);
    chk("m_done_c3",    32'(dm_done),        0);
    chk("m_stall_c3",   32'(stall_mem),      1);
    tick();
    chk("m_req_c4",  32'(mem_if.mem_req), 1);
    chk("m_addr_c4", mem_if.mem_addr,     32'h304);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("m_done_c5", 32'(dm_done), 1);
    chk("m_rd_c5",   dm_rdata,     32'h5A5A5A5A);
    dm_req = 1'b0;
    tick();

    // Starvation: if_req withdrawn only during dm_done cycles so it is eligible at each grant
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_addr = 32'h400 + 32'(i * 4);
      tick();
      chk("sv_owner",  32'(owner),         1);
      chk("sv_addr",   mem_if.mem_addr,    32'h400 + 32'(i * 4));
      chk("sv_starve", 32'(dut.starve_q),  32'(i + 1));
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hB0 + 32'(i);
      tick();
      mem_if.mem_ack = 1'b0;
      chk("sv_done", 32'(dm_done), 1);
      if_req = 1'b0;
      tick();
      chk("sv_idle", 32'(mem_if.mem_req), 0);
      if_req = 1'b1;
    end
    dm_addr = 32'h410;
    tick();
    chk("sv_f_owner",  32'(owner),        0);
    chk("sv_f_addr",   mem_if.mem_addr,   32'h500);
    chk("sv_f_starve", 32'(dut.starve_q), 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h600D0001;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("sv_f_done", 32'(if_done), 1);
    chk("sv_f_rd",   if_rdata,     32'h600D0001);
    tick();
    chk("sv_d6_owner",  32'(owner),        1);
    chk("sv_d6_addr",   mem_if.mem_addr,   32'h410);
    chk("sv_d6_starve", 32'(dut.starve_q), 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hB4;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("sv_d6_done", 32'(dm_done), 1);
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Reset during a data wait, late ack afterwards
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h600; dm_wdata = 32'h77;
    tick();
    chk("r_req_c1",   32'(mem_if.mem_req), 1);
    chk("r_we_c1",    32'(mem_if.mem_we),  1);
    chk("r_wdata_c1", mem_if.mem_wdata,    32'h77);
    tick();
    rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("r_req_c2",  32'(mem_if.mem_req), 0);
    chk("r_we_c2",   32'(mem_if.mem_we),  0);
    chk("r_busy_c2", 32'(busy),           0);
    chk("r_addr_c2", mem_if.mem_addr,     0);
    chk("r_drd_c2",  dm_rdata,            0);
    tick();
    rst = 1'b1;
    tick();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hFFFF0000;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("r_done_c5", 32'(dm_done),        0);
    chk("r_ifd_c5",  32'(if_done),        0);
    chk("r_req_c5",  32'(mem_if.mem_req), 0);
    chk("r_drd_c5",  dm_rdata,            0);
    tick();
    chk("r_done_c6", 32'(dm_done), 0);
    chk("r_busy_c6", 32'(busy),    0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
